// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_responder_if : request/response bus between a core and dmem_responder
// Revision: 1.0
// ============================================================================
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN/8-1:0] req_wmask;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : single-outstanding data memory with fixed-latency response.
// Optional RISCV_FORMAL_DMEM_ZEROINIT_EN: zero-fill sweep after reset.
// Revision: 1.0
// ============================================================================
module dmem_responder #(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  dmem_responder_if.slave   bus
);
  localparam int NB    = XLEN / 8;
  localparam int W     = $clog2(NB);
  localparam int AW    = DEPTH_LOG2 + W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [NB-1:0]         wmask_q, wmask_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic [XLEN-1:0]       mem_q [DEPTH];
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [NB-1:0]         wr_be;
  logic [XLEN-1:0]       wr_data;

`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
  logic [DEPTH_LOG2-1:0] init_idx_q, init_idx_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) init_idx_q <= '0;
    else         init_idx_q <= init_idx_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    wr_en       = 1'b0;
    wr_idx      = addr_q[AW-1:W];
    wr_be       = wmask_q;
    wr_data     = wdata_q;
`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
    init_idx_d  = init_idx_q;
`endif
    case (state_q)
      INIT: begin
`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
        wr_en      = 1'b1;
        wr_idx     = init_idx_q;
        wr_be      = '1;
        wr_data    = '0;
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr[AW-1:0];
          wmask_d = bus.req_wmask;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          // Misaligned accesses report an error and leave memory untouched.
          if (addr_q[W-1:0] != '0) begin
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            rsp_error_d = 1'b0;
            rsp_rdata_d = mem_q[addr_q[AW-1:W]];
            wr_en       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Storage has no reset; the read above samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  generate
    if (AW < XLEN) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[XLEN-1:AW];
    end
  endgenerate

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : randomized bench against a word/byte-level memory model.
// Revision: 1.0
// ============================================================================
module tb_dmem_responder;
  localparam int XLEN       = 32;
  localparam int DEPTH_LOG2 = 4;
  localparam int LATENCY    = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.XLEN(XLEN)) bus ();

  dmem_responder #(
    .XLEN(XLEN), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: word contents plus per-byte "known" flags (uninitialised bytes are don't-care).
  logic [31:0] model_mem [DEPTH];
  logic [3:0]  model_kn  [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_kn[i]  = 4'hF;
    end
`endif
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
    check_eq({tag, "_init_cycles"}, n, DEPTH);
`else
    check_eq({tag, "_init_cycles"}, n, 0);
`endif
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                        input int hold);
    logic [31:0] exp_rd, kmask;
    logic        exp_err;
    int          lat, idx;
    idx   = int'(a[DEPTH_LOG2+1:2]);
    kmask = 32'hFFFF_FFFF;
    if (a[1:0] != 2'b00) begin
      exp_err = 1'b1;
      exp_rd  = '0;
    end else begin
      exp_err = 1'b0;
      exp_rd  = model_mem[idx];
      for (int b = 0; b < 4; b++) begin
        if (!model_kn[idx][b]) kmask[8*b +: 8] = 8'h00;
        if (m[b]) begin
          model_mem[idx][8*b +: 8] = d[8*b +: 8];
          model_kn[idx][b]         = 1'b1;
        end
      end
    end

    @(negedge clk);
    check_eq("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    // Garbage on the request side while busy must be ignored.
    bus.req_addr  = $urandom;
    bus.req_wmask = 4'($urandom);
    bus.req_wdata = $urandom;
    lat = 0;
    do begin
      check_eq("req_ready_busy", bus.req_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    check_eq("latency", lat, LATENCY);
    check_eq("rsp_error", bus.rsp_error, exp_err);
    check_eq("rsp_rdata", bus.rsp_rdata & kmask, exp_rd & kmask);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", bus.rsp_valid, 1'b1);
      check_eq("hold_rdata", bus.rsp_rdata & kmask, exp_rd & kmask);
      check_eq("hold_error", bus.rsp_error, exp_err);
      check_eq("hold_ready", bus.req_ready, 1'b0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("rsp_valid_clr", bus.rsp_valid, 1'b0);
    check_eq("req_ready_back", bus.req_ready, 1'b1);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  m;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_kn[i]  = 4'h0;
    end
    model_reset();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_error", bus.rsp_error, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    wait_ready("first");

`ifdef RISCV_FORMAL_DMEM_ZEROINIT_EN
    do_txn(32'h3C, 4'h0, 32'h0, 0);
`endif
    do_txn(32'h10, 4'hF, 32'hDEADBEEF, 0);
    do_txn(32'h10, 4'h0, 32'h0, 0);
    do_txn(32'h10, 4'h1, 32'h000000AA, 1);
    do_txn(32'h10, 4'h0, 32'h0, 0);
    do_txn(32'h12, 4'hF, 32'h55555555, 0);
    do_txn(32'h10, 4'h0, 32'h0, 0);
    do_txn(32'h40, 4'hF, 32'h11223344, 5);
    do_txn(32'h00, 4'h0, 32'h0, 0);
    do_txn(32'h20, 4'hF, 32'hCAFEF00D, 2);

    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      d = $urandom;
      do_txn(a, m, d, $urandom_range(0, 3));
    end
    do_txn(32'h20, 4'hF, 32'hCAFEF00D, 0);

    // Abort a write one cycle before its access edge.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wmask = 4'hF;
    bus.req_wdata = 32'h0BADC0DE;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (LATENCY - 1) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    wait_ready("abort");
    do_txn(32'h20, 4'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
